muldiv: RTL and testbench
=========================

# muldiv

Iterative multiply/divide unit sitting directly downstream of the general-purpose register file. It consumes the two register read buses (busa = rs value, busb = rt value) and executes MIPS mult, multu, div and divu over 32 cycles, holding results in internal HI/LO registers. It also services mthi/mtlo writes. The controller stalls on busy and reads HI/LO for mfhi/mflo.

## Interface
Parameters: none. Width is fixed at 32 bits and iteration count at 32.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin an operation; sampled only when busy=0
- op  input  2  operation select: 00 mult, 01 multu, 10 div, 11 divu
- busa  input  32  operand A (rs); dividend / multiplicand; also mthi/mtlo data
- busb  input  32  operand B (rt); divisor / multiplier
- hiwrite  input  1  mthi: HI <= busa
- lowrite  input  1  mtlo: LO <= busa
- busy  output  1  high while an operation is in progress
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- FSM states:
  - IDLE: wait for start.
  - MUL: 32 shift-add iterations.
  - DIV: 32 restoring shift-subtract iterations.
- IDLE, start=1:
  - Latch op, sign flags, and operand magnitudes.
  - Signed ops take the absolute value. |0x8000_0000| = 0x8000_0000 as unsigned.
  - Unsigned ops use operands as-is.
  - Clear the 5-bit iteration counter.
  - Go to MUL (op[1]=0) or DIV (op[1]=1).
- MUL/DIV: one iteration per cycle; counter increments each cycle.
- Final iteration (counter = 31):
  - Apply sign correction and write HI/LO.
  - Return to IDLE.
- Multiply result: 64-bit product. HI = product[63:32], LO = product[31:0].
  - Signed: negate the 64-bit product if sign(A) XOR sign(B).
- Divide result: LO = quotient, HI = remainder.
  - Signed: quotient negated if sign(A) XOR sign(B); remainder takes the sign of the dividend.
  - Divide by zero (busb = 0 at start), any signedness: LO = 0xFFFF_FFFF, HI = original busa. Still takes the full 32 cycles.
  - Signed 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0.
- HI/LO are unchanged during an operation until the final edge.
- mthi/mtlo, only when busy=0 and start=0:
  - hiwrite → HI <= busa; lowrite → LO <= busa.
  - Both may be asserted in the same cycle.
- Ignored inputs:
  - start while busy=1.
  - hiwrite/lowrite while busy=1.
  - hiwrite/lowrite in the same cycle as an accepted start (start wins).
- op, busa and busb are don't-care after the start edge; operands are latched.

## Timing
- Reset, synchronous at the clock edge with reset=1:
  - State IDLE, busy=0, hi=0, lo=0, counter=0.
  - Any operation in progress is abandoned.
- Reset has priority over start, hiwrite and lowrite.
- start accepted at edge E0. busy=1 from after E0 through edges E1..E32.
- HI/LO are written at E32, and busy falls at that same edge.
- Busy is high for exactly 32 cycles. Results are valid the cycle after E32.
- A new start may be accepted at E33 (first cycle with busy=0).
- Back-to-back: a start held high continuously is accepted again at E33, not earlier.
- mthi/mtlo: value visible on hi/lo one cycle after the write edge.
- busy, hi and lo are registered outputs with no combinational path from inputs.

## Test plan
- Unsigned multiply:
  - Stimulus: multu, busa = 0xFFFF_FFFF, busb = 0xFFFF_FFFF.
  - Required: busy high exactly 32 cycles; then hi = 0xFFFF_FFFE, lo = 0x0000_0001.
- Signed multiply, start ignored while busy:
  - Stimulus: mult, busa = 0xFFFF_FFFD (-3), busb = 7. Pulse start again at cycle 10 with different operands.
  - Required: second start ignored; hi = 0xFFFF_FFFF, lo = 0xFFFF_FFEB (-21).
- Signed divide:
  - Stimulus: div, busa = 0xFFFF_FFF9 (-7), busb = 2.
  - Required: lo = 0xFFFF_FFFD (-3), hi = 0xFFFF_FFFF (-1).
- Unsigned divide, including divide by zero:
  - Stimulus 1: divu, busa = 100, busb = 7. Required: lo = 14, hi = 2.
  - Stimulus 2: divu, busa = 0x1234_5678, busb = 0. Required: lo = 0xFFFF_FFFF, hi = 0x1234_5678, busy still 32 cycles.
- mthi/mtlo and write lockout:
  - Stimulus: idle, hiwrite with busa = 0xABCD_EF12; next cycle lowrite with busa = 0x0000_0055.
  - Required: hi = 0xABCD_EF12, lo = 0x55.
  - Stimulus: hiwrite during an operation. Required: no effect.
- Reset mid-operation:
  - Stimulus: start mult, assert reset at cycle 15 for one cycle.
  - Required: next cycle busy = 0, hi = 0, lo = 0.
  - Stimulus: fresh multu 6 × 7. Required: lo = 42, hi = 0 after 32 cycles.

Source files
------------

// File: rtl/muldiv.sv
// muldiv: iterative 32-bit multiply/divide unit with HI/LO result registers.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; mthi/mtlo writes serviced here
// MUL   | 32 shift-add iterations on operand magnitudes
// DIV   | 32 restoring shift-subtract iterations on operand magnitudes
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   start    begin an operation (accepted only when idle)
//   op       00 mult, 01 multu, 10 div, 11 divu
//   busa     operand A (multiplicand / dividend), also mthi/mtlo data
//   busb     operand B (multiplier / divisor)
//   hiwrite  mthi: HI <= busa when idle and not starting
//   lowrite  mtlo: LO <= busa when idle and not starting
//   busy     high while an operation is in progress
//   hi, lo   HI and LO result registers
module muldiv (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] busa,
   input  logic [31:0] busb,
   input  logic        hiwrite,
   input  logic        lowrite,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   // acc: upper product half (MUL) or partial remainder (DIV)
   logic [31:0] acc_q, acc_d;
   // sh: multiplier being consumed (MUL) or dividend/quotient (DIV)
   logic [31:0] sh_q, sh_d;
   // opb: multiplicand (MUL) or divisor (DIV) magnitude
   logic [31:0] opb_q, opb_d;
   logic [31:0] orig_a_q, orig_a_d;
   logic        neg_res_q, neg_res_d;
   logic        neg_rem_q, neg_rem_d;
   logic        dz_q, dz_d;

   logic        sign_a, sign_b;
   logic [31:0] mag_a, mag_b;
   logic [32:0] mul_sum;
   logic [31:0] mul_acc_nxt, mul_sh_nxt;
   logic [63:0] prod, mul_res;
   logic [32:0] div_diff;
   logic        div_ge;
   logic [31:0] div_acc_nxt, div_sh_nxt;
   logic [31:0] quo_res, rem_res;
   logic        last_iter;

   // Signed ops work on magnitudes; |0x8000_0000| stays 0x8000_0000 unsigned.
   assign sign_a = ~op[0] & busa[31];
   assign sign_b = ~op[0] & busb[31];
   assign mag_a  = sign_a ? (~busa + 32'd1) : busa;
   assign mag_b  = sign_b ? (~busb + 32'd1) : busb;

   // One shift-add step: add multiplicand when the multiplier LSB is set,
   // then shift the 65-bit {carry, acc, sh} right by one.
   assign mul_sum     = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : 33'd0);
   assign mul_acc_nxt = mul_sum[32:1];
   assign mul_sh_nxt  = {mul_sum[0], sh_q[31:1]};
   assign prod        = {mul_acc_nxt, mul_sh_nxt};
   assign mul_res     = neg_res_q ? (~prod + 64'd1) : prod;

   // One restoring step: shift next dividend bit into the remainder and keep
   // the difference only if it did not borrow.
   assign div_diff    = {acc_q, sh_q[31]} - {1'b0, opb_q};
   assign div_ge      = ~div_diff[32];
   assign div_acc_nxt = div_ge ? div_diff[31:0] : {acc_q[30:0], sh_q[31]};
   assign div_sh_nxt  = {sh_q[30:0], div_ge};
   assign quo_res     = neg_res_q ? (~div_sh_nxt + 32'd1) : div_sh_nxt;
   assign rem_res     = neg_rem_q ? (~div_acc_nxt + 32'd1) : div_acc_nxt;

   assign last_iter   = (cnt_q == 5'd31);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      acc_d     = acc_q;
      sh_d      = sh_q;
      opb_d     = opb_q;
      orig_a_d  = orig_a_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = op[1] ? ST_DIV : ST_MUL;
               cnt_d     = 5'd0;
               acc_d     = 32'd0;
               sh_d      = op[1] ? mag_a : mag_b;
               opb_d     = op[1] ? mag_b : mag_a;
               orig_a_d  = busa;
               neg_res_d = sign_a ^ sign_b;
               neg_rem_d = sign_a;
               dz_d      = (busb == 32'd0);
            end else begin
               if (hiwrite) hi_d = busa;
               if (lowrite) lo_d = busa;
            end
         end

         ST_MUL: begin
            acc_d = mul_acc_nxt;
            sh_d  = mul_sh_nxt;
            cnt_d = cnt_q + 5'd1;
            if (last_iter) begin
               hi_d    = mul_res[63:32];
               lo_d    = mul_res[31:0];
               state_d = ST_IDLE;
            end
         end

         ST_DIV: begin
            acc_d = div_acc_nxt;
            sh_d  = div_sh_nxt;
            cnt_d = cnt_q + 5'd1;
            if (last_iter) begin
               // Divide by zero reports the raw dividend regardless of sign.
               hi_d    = dz_q ? orig_a_q : rem_res;
               lo_d    = dz_q ? 32'hFFFF_FFFF : quo_res;
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 5'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         acc_q     <= 32'd0;
         sh_q      <= 32'd0;
         opb_q     <= 32'd0;
         orig_a_q  <= 32'd0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         acc_q     <= acc_d;
         sh_q      <= sh_d;
         opb_q     <= opb_d;
         orig_a_q  <= orig_a_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
module tb_muldiv;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] busa = 32'd0;
   logic [31:0] busb = 32'd0;
   logic        hiwrite = 1'b0;
   logic        lowrite = 1'b0;
   logic        busy;
   logic [31:0] hi, lo;

   int total = 0;
   int bad   = 0;

   muldiv dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .busa(busa), .busb(busb), .hiwrite(hiwrite), .lowrite(lowrite),
      .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Reference: MIPS semantics with plain 64-bit arithmetic, returns {hi, lo}.
   function automatic logic [63:0] ref_md(input logic [1:0] f_op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, uq, ur;
      logic [63:0]     res;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      res = 64'd0;
      case (f_op)
         2'd0: res = 64'(sa * sb);
         2'd1: res = ua * ub;
         default: begin
            if (b == 32'd0) begin
               res = {a, 32'hFFFF_FFFF};
            end else if (f_op == 2'd2) begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end else begin
               uq = ua / ub;
               ur = ua % ub;
               res = {ur[31:0], uq[31:0]};
            end
         end
      endcase
      return res;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Starts one op and waits for completion; optional noise drives start,
   // hiwrite and lowrite while busy. Reports busy length and whether hi/lo
   // stayed put during the operation.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit noise,
                         output int cyc, output logic [31:0] rhi,
                         output logic [31:0] rlo, output bit held);
      logic [31:0] h0, l0;
      h0 = hi;
      l0 = lo;
      held = 1'b1;
      start = 1'b1; op = o; busa = a; busb = b;
      tick();
      start = 1'b0;
      op = 2'($urandom);
      busa = $urandom;
      busb = $urandom;
      cyc = 0;
      while (busy && cyc < 40) begin
         cyc++;
         if (hi !== h0 || lo !== l0) held = 1'b0;
         if (noise) begin
            start   = 1'($urandom);
            hiwrite = 1'($urandom);
            lowrite = 1'($urandom);
            busa    = $urandom;
         end
         tick();
      end
      start = 1'b0; hiwrite = 1'b0; lowrite = 1'b0;
      rhi = hi;
      rlo = lo;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
      total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
   endtask

   task automatic test_multu;
      int cyc; logic [31:0] rh, rl; bit held; logic [63:0] e;
      e = ref_md(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cyc, rh, rl, held);
      total++; if (cyc !== 32) begin bad++; $display("FAIL multu_cycles got=%0d exp=32", cyc); end
      total++; if (rh !== e[63:32]) begin bad++; $display("FAIL multu_hi got=%h exp=%h", rh, e[63:32]); end
      total++; if (rl !== e[31:0]) begin bad++; $display("FAIL multu_lo got=%h exp=%h", rl, e[31:0]); end
      total++; if (!held) begin bad++; $display("FAIL multu_hold got=changed exp=stable"); end
   endtask

   task automatic test_mult_ignore;
      int cyc; logic [63:0] e;
      e = ref_md(2'd0, 32'hFFFF_FFFD, 32'd7);
      hiwrite = 1'b1; busa = 32'h0F0F_0F0F;
      tick();
      hiwrite = 1'b0;
      start = 1'b1; op = 2'd0; busa = 32'hFFFF_FFFD; busb = 32'd7;
      tick();
      start = 1'b0;
      cyc = 0;
      while (busy && cyc < 40) begin
         cyc++;
         start = (cyc == 10);
         if (cyc == 10) begin op = 2'd1; busa = 32'd5; busb = 32'd9; end
         hiwrite = (cyc == 20);
         if (cyc == 20) busa = 32'hDEAD_BEEF;
         if (cyc == 21) begin
            total++; if (hi !== 32'h0F0F_0F0F) begin bad++; $display("FAIL lockout_hi got=%h exp=0f0f0f0f", hi); end
         end
         tick();
      end
      start = 1'b0; hiwrite = 1'b0;
      total++; if (cyc !== 32) begin bad++; $display("FAIL mult_cycles got=%0d exp=32", cyc); end
      total++; if (hi !== e[63:32]) begin bad++; $display("FAIL mult_hi got=%h exp=%h", hi, e[63:32]); end
      total++; if (lo !== e[31:0]) begin bad++; $display("FAIL mult_lo got=%h exp=%h", lo, e[31:0]); end
   endtask

   task automatic test_div;
      logic [31:0] va [4] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FF00, 32'd37};
      logic [31:0] vb [4] = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFB};
      int cyc; logic [31:0] rh, rl; bit held; logic [63:0] e;
      for (int i = 0; i < 4; i++) begin
         e = ref_md(2'd2, va[i], vb[i]);
         run_op(2'd2, va[i], vb[i], 1'b0, cyc, rh, rl, held);
         total++; if (rh !== e[63:32] || rl !== e[31:0])
            begin bad++; $display("FAIL div_%0d got=%h_%h exp=%h_%h", i, rh, rl, e[63:32], e[31:0]); end
         total++; if (cyc !== 32) begin bad++; $display("FAIL div_cycles_%0d got=%0d exp=32", i, cyc); end
      end
   endtask

   task automatic test_divu;
      int cyc; logic [31:0] rh, rl; bit held;
      run_op(2'd3, 32'd100, 32'd7, 1'b0, cyc, rh, rl, held);
      total++; if (rl !== 32'd14) begin bad++; $display("FAIL divu_lo got=%h exp=e", rl); end
      total++; if (rh !== 32'd2) begin bad++; $display("FAIL divu_hi got=%h exp=2", rh); end
      run_op(2'd3, 32'h1234_5678, 32'd0, 1'b0, cyc, rh, rl, held);
      total++; if (rl !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divz_lo got=%h exp=ffffffff", rl); end
      total++; if (rh !== 32'h1234_5678) begin bad++; $display("FAIL divz_hi got=%h exp=12345678", rh); end
      total++; if (cyc !== 32) begin bad++; $display("FAIL divz_cycles got=%0d exp=32", cyc); end
   endtask

   task automatic test_mthi_mtlo;
      int cyc; logic [63:0] e;
      hiwrite = 1'b1; busa = 32'hABCD_EF12;
      tick();
      hiwrite = 1'b0; lowrite = 1'b1; busa = 32'h0000_0055;
      tick();
      lowrite = 1'b0;
      total++; if (hi !== 32'hABCD_EF12) begin bad++; $display("FAIL mthi got=%h exp=abcdef12", hi); end
      total++; if (lo !== 32'h55) begin bad++; $display("FAIL mtlo got=%h exp=55", lo); end
      hiwrite = 1'b1; lowrite = 1'b1; busa = 32'h1357_2468;
      tick();
      hiwrite = 1'b0; lowrite = 1'b0;
      total++; if (hi !== 32'h1357_2468 || lo !== 32'h1357_2468)
         begin bad++; $display("FAIL mthilo_both got=%h_%h exp=13572468_13572468", hi, lo); end
      // start in the same cycle as writes: the operation wins
      e = ref_md(2'd1, 32'h1111_1111, 32'h10);
      start = 1'b1; op = 2'd1; busa = 32'h1111_1111; busb = 32'h10;
      hiwrite = 1'b1; lowrite = 1'b1;
      tick();
      start = 1'b0; hiwrite = 1'b0; lowrite = 1'b0;
      cyc = 0;
      while (busy && cyc < 40) begin cyc++; tick(); end
      total++; if (hi !== e[63:32] || lo !== e[31:0])
         begin bad++; $display("FAIL start_wins got=%h_%h exp=%h_%h", hi, lo, e[63:32], e[31:0]); end
   endtask

   task automatic test_reset_mid;
      int cyc; logic [31:0] rh, rl; bit held;
      hiwrite = 1'b1; lowrite = 1'b1; busa = 32'h5A5A_A5A5;
      tick();
      hiwrite = 1'b0; lowrite = 1'b0;
      start = 1'b1; op = 2'd0; busa = 32'h1234_0001; busb = 32'h8765_4321;
      tick();
      start = 1'b0;
      for (int i = 1; i < 15; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      total++; if (hi !== 32'd0 || lo !== 32'd0)
         begin bad++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", hi, lo); end
      run_op(2'd1, 32'd6, 32'd7, 1'b0, cyc, rh, rl, held);
      total++; if (rl !== 32'd42 || rh !== 32'd0 || cyc !== 32)
         begin bad++; $display("FAIL rstmid_multu got=%h_%h/%0d exp=0_2a/32", rh, rl, cyc); end
   endtask

   task automatic test_back_to_back;
      int cyc; logic [63:0] e1, e2;
      e1 = ref_md(2'd0, 32'hFFFF_FF85, 32'h0001_0003);
      e2 = ref_md(2'd3, 32'hF000_0001, 32'd13);
      start = 1'b1; op = 2'd0; busa = 32'hFFFF_FF85; busb = 32'h0001_0003;
      tick();
      op = 2'd3; busa = 32'hF000_0001; busb = 32'd13;
      cyc = 0;
      while (busy && cyc < 40) begin cyc++; tick(); end
      total++; if (cyc !== 32) begin bad++; $display("FAIL b2b_first_cycles got=%0d exp=32", cyc); end
      total++; if (hi !== e1[63:32] || lo !== e1[31:0])
         begin bad++; $display("FAIL b2b_first got=%h_%h exp=%h_%h", hi, lo, e1[63:32], e1[31:0]); end
      tick();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_reaccept got=%b exp=1", busy); end
      start = 1'b0;
      cyc = 1;
      while (busy && cyc < 40) begin cyc++; tick(); end
      total++; if (cyc !== 33 || hi !== e2[63:32] || lo !== e2[31:0])
         begin bad++; $display("FAIL b2b_second got=%h_%h/%0d exp=%h_%h/33", hi, lo, cyc, e2[63:32], e2[31:0]); end
   endtask

   task automatic test_random;
      logic [31:0] corner [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      int cyc; logic [31:0] rh, rl, a, b; bit held; logic [1:0] o; logic [63:0] e;
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom);
         a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 28);
         e = ref_md(o, a, b);
         run_op(o, a, b, 1'b1, cyc, rh, rl, held);
         total++; if (rh !== e[63:32] || rl !== e[31:0])
            begin bad++; $display("FAIL rand_%0d op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, o, a, b, rh, rl, e[63:32], e[31:0]); end
         total++; if (cyc !== 32 || !held)
            begin bad++; $display("FAIL rand_busy_%0d got=%0d/held=%0d exp=32/held=1", i, cyc, held); end
      end
   endtask

   initial begin
      test_reset();
      test_multu();
      test_mult_ignore();
      test_div();
      test_divu();
      test_mthi_mtlo();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
